// File: rtl/fp_div_share_arbiter.sv
// fp_div_share_arbiter
//   Shares one iterative mantissa divider between the FDIV requester and the
//   FSQRT Newton-Raphson controller. One requester is granted at a time with
//   round-robin fairness on ties; the winner's operands are latched and held
//   stable for the divider until the next launch. The divider start/stall
//   handshake is sequenced here and the quotient is returned to the owner with
//   a one-cycle done pulse. A watchdog aborts a transaction that never
//   completes.
// Ports
//   in_Clk, in_Rst_N                  clock (rising edge), async active-low reset
//   in_flush                          abandon the current transaction
//   in_div_req / in_div_dividend / in_div_divisor      FDIV request + operands
//   out_div_grant / out_div_done / out_div_quotient    FDIV ownership + result
//   in_sqrt_req / in_sqrt_dividend / in_sqrt_divisor   FSQRT request + operands
//   out_sqrt_grant / out_sqrt_done / out_sqrt_quotient FSQRT ownership + result
//   out_dvd_start / out_dvd_dividend / out_dvd_divisor divider launch + operands
//   in_dvd_stall / in_dvd_quotient    divider busy flag + result
//   out_error                         one-cycle pulse on watchdog abort
module fp_div_share_arbiter #(
  parameter int unsigned DATA_WIDTH = 254,
  parameter int unsigned TIMEOUT    = 512
) (
  input  logic                  in_Clk,
  input  logic                  in_Rst_N,
  input  logic                  in_flush,
  input  logic                  in_div_req,
  input  logic [DATA_WIDTH-1:0] in_div_dividend,
  input  logic [DATA_WIDTH-1:0] in_div_divisor,
  output logic                  out_div_grant,
  output logic                  out_div_done,
  output logic [DATA_WIDTH:0]   out_div_quotient,
  input  logic                  in_sqrt_req,
  input  logic [DATA_WIDTH-1:0] in_sqrt_dividend,
  input  logic [DATA_WIDTH-1:0] in_sqrt_divisor,
  output logic                  out_sqrt_grant,
  output logic                  out_sqrt_done,
  output logic [DATA_WIDTH:0]   out_sqrt_quotient,
  output logic                  out_dvd_start,
  output logic [DATA_WIDTH:0]   out_dvd_dividend,
  output logic [DATA_WIDTH-1:0] out_dvd_divisor,
  input  logic                  in_dvd_stall,
  input  logic [DATA_WIDTH:0]   in_dvd_quotient,
  output logic                  out_error
);

  localparam int unsigned TW = $clog2(TIMEOUT + 1);

  localparam logic [2:0] S_IDLE      = 3'd0;
  localparam logic [2:0] S_LAUNCH    = 3'd1;
  localparam logic [2:0] S_WAIT_BUSY = 3'd2;
  localparam logic [2:0] S_WAIT_DONE = 3'd3;
  localparam logic [2:0] S_RESP      = 3'd4;
  localparam logic [2:0] S_DRAIN     = 3'd5;

  localparam logic OWN_DIV  = 1'b0;
  localparam logic OWN_SQRT = 1'b1;

  logic [2:0]            state;
  logic [2:0]            state_nxt;
  logic                  owner;
  logic                  last_winner;
  logic [DATA_WIDTH-1:0] dividend_q;
  logic [DATA_WIDTH-1:0] divisor_q;
  logic [DATA_WIDTH:0]   div_quot_q;
  logic [DATA_WIDTH:0]   sqrt_quot_q;
  logic [TW-1:0]         timer;

  logic any_req;
  logic win_sqrt;
  logic accept;
  logic waiting;
  logic timeout;
  logic capture;

  always_comb begin
    any_req  = in_div_req | in_sqrt_req;
    // On a tie the requester that did not win last time is served.
    win_sqrt = in_sqrt_req & (~in_div_req | (last_winner == OWN_DIV));
    accept   = (state == S_IDLE) && any_req && !in_flush;
    waiting  = (state == S_WAIT_BUSY) || (state == S_WAIT_DONE) || (state == S_DRAIN);
    timeout  = waiting && (timer == TW'(TIMEOUT - 1));
    capture  = (state == S_WAIT_DONE) && !in_dvd_stall && !in_flush && !timeout;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:      if (accept) state_nxt = S_LAUNCH;
      S_LAUNCH:    state_nxt = in_flush ? S_DRAIN : S_WAIT_BUSY;
      S_WAIT_BUSY: begin
        if (timeout)           state_nxt = S_IDLE;
        // Flushed before the divider went busy: nothing to drain.
        else if (in_flush)     state_nxt = in_dvd_stall ? S_DRAIN : S_IDLE;
        else if (in_dvd_stall) state_nxt = S_WAIT_DONE;
      end
      S_WAIT_DONE: begin
        if (timeout)            state_nxt = S_IDLE;
        else if (in_flush)      state_nxt = S_DRAIN;
        else if (!in_dvd_stall) state_nxt = S_RESP;
      end
      S_RESP:      state_nxt = S_IDLE;
      S_DRAIN:     if (timeout || !in_dvd_stall) state_nxt = S_IDLE;
      default:     state_nxt = S_IDLE;
    endcase
  end

  always_ff @(posedge in_Clk or negedge in_Rst_N) begin
    if (!in_Rst_N) begin
      state       <= S_IDLE;
      owner       <= OWN_DIV;
      last_winner <= OWN_SQRT;
      dividend_q  <= '0;
      divisor_q   <= '0;
      div_quot_q  <= '0;
      sqrt_quot_q <= '0;
      timer       <= '0;
    end else begin
      state <= state_nxt;
      if (accept) begin
        owner      <= win_sqrt;
        dividend_q <= win_sqrt ? in_sqrt_dividend : in_div_dividend;
        divisor_q  <= win_sqrt ? in_sqrt_divisor  : in_div_divisor;
      end
      if (state == S_LAUNCH)
        timer <= '0;
      else if (waiting)
        timer <= timer + TW'(1);
      if (capture) begin
        if (owner == OWN_SQRT) sqrt_quot_q <= in_dvd_quotient;
        else                   div_quot_q  <= in_dvd_quotient;
      end
      if ((state == S_RESP) || timeout)
        last_winner <= owner;
    end
  end

  always_comb begin
    out_div_grant     = (state != S_IDLE) && (state != S_DRAIN) && (owner == OWN_DIV);
    out_sqrt_grant    = (state != S_IDLE) && (state != S_DRAIN) && (owner == OWN_SQRT);
    out_div_done      = (state == S_RESP) && (owner == OWN_DIV);
    out_sqrt_done     = (state == S_RESP) && (owner == OWN_SQRT);
    out_div_quotient  = div_quot_q;
    out_sqrt_quotient = sqrt_quot_q;
    out_dvd_start     = (state == S_LAUNCH);
    out_dvd_dividend  = {1'b0, dividend_q};
    out_dvd_divisor   = divisor_q;
    out_error         = timeout;
  end

endmodule

// File: tb/tb_fp_div_share_arbiter.sv
// Testbench for fp_div_share_arbiter: behavioural divider responder,
// scoreboard of expected (owner, quotient) per transaction, table-driven
// single-requester vectors plus hand-written multi-cycle sequences.
module tb_fp_div_share_arbiter;

  localparam int unsigned DW = 254;
  localparam int unsigned TO = 512;
  localparam int unsigned QW = DW + 1;

  logic          clk = 1'b0;
  logic          rst_n;
  logic          flush;
  logic          div_req, sqrt_req;
  logic [DW-1:0] div_dvd, div_dvs, sqrt_dvd, sqrt_dvs;
  logic          div_grant, div_done, sqrt_grant, sqrt_done;
  logic [DW:0]   div_quot, sqrt_quot;
  logic          dvd_start;
  logic [DW:0]   dvd_dividend;
  logic [DW-1:0] dvd_divisor;
  logic          dvd_stall;
  logic [DW:0]   dvd_quot;
  logic          error;

  always #5 clk = ~clk;

  fp_div_share_arbiter #(.DATA_WIDTH(DW), .TIMEOUT(TO)) dut (
    .in_Clk            (clk),
    .in_Rst_N          (rst_n),
    .in_flush          (flush),
    .in_div_req        (div_req),
    .in_div_dividend   (div_dvd),
    .in_div_divisor    (div_dvs),
    .out_div_grant     (div_grant),
    .out_div_done      (div_done),
    .out_div_quotient  (div_quot),
    .in_sqrt_req       (sqrt_req),
    .in_sqrt_dividend  (sqrt_dvd),
    .in_sqrt_divisor   (sqrt_dvs),
    .out_sqrt_grant    (sqrt_grant),
    .out_sqrt_done     (sqrt_done),
    .out_sqrt_quotient (sqrt_quot),
    .out_dvd_start     (dvd_start),
    .out_dvd_dividend  (dvd_dividend),
    .out_dvd_divisor   (dvd_divisor),
    .in_dvd_stall      (dvd_stall),
    .in_dvd_quotient   (dvd_quot),
    .out_error         (error)
  );

  int unsigned tests = 0;
  int unsigned fails = 0;
  int          cyc   = 0;
  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input logic [QW-1:0] act, input logic [QW-1:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  // Scoreboard entry: which requester must be answered, with what operands/result.
  typedef struct {
    logic          is_sqrt;
    logic [DW-1:0] dvd;
    logic [DW-1:0] dvs;
    logic [DW:0]   q;
  } sb_t;
  sb_t sb[$];

  task automatic push(input logic s, input logic [DW-1:0] a, input logic [DW-1:0] b,
                      input logic [DW:0] q);
    sb_t e;
    e.is_sqrt = s; e.dvd = a; e.dvs = b; e.q = q;
    sb.push_back(e);
  endtask

  // Divider responder: stall rises one cycle after start and stays high for
  // stall_len cycles; the quotient is only meaningful in the cycle stall falls.
  int          stall_len   = 4;
  bit          never_stall = 1'b0;
  bit          pend, fell;
  int          cnt;
  logic [DW:0] qreal;

  function automatic logic [DW:0] garbage();
    logic [255:0] t;
    for (int i = 0; i < 8; i++) t[i*32 +: 32] = $urandom;
    return t[DW:0];
  endfunction

  always @(negedge clk or negedge rst_n) begin
    if (!rst_n) begin
      dvd_stall = 1'b0; pend = 1'b0; fell = 1'b0; cnt = 0; dvd_quot = '0;
    end else begin
      if (fell) begin dvd_quot = garbage(); fell = 1'b0; end
      if (pend) begin
        pend = 1'b0;
        dvd_stall = 1'b1;
        cnt = stall_len - 1;
        qreal = (dvd_dividend << 1) / {1'b0, dvd_divisor};
        dvd_quot = garbage();
      end else if (dvd_stall) begin
        if (cnt == 0) begin dvd_stall = 1'b0; dvd_quot = qreal; fell = 1'b1; end
        else cnt--;
      end
      if (dvd_start && !never_stall) pend = 1'b1;
    end
  end

  // Monitor: grant exclusivity, launch operands, operand stability, results.
  logic [DW:0]   st_dvd;
  logic [DW-1:0] st_dvs;
  always @(negedge clk) begin
    if (rst_n) begin
      if (div_grant || sqrt_grant)
        chk("grant_onehot", QW'(div_grant & sqrt_grant), '0);
      if (dvd_start) begin
        st_dvd = dvd_dividend;
        st_dvs = dvd_divisor;
        if (sb.size() > 0) begin
          chk("start_dividend", dvd_dividend, {1'b0, sb[0].dvd});
          chk("start_divisor", QW'(dvd_divisor), QW'(sb[0].dvs));
        end
      end else if (dvd_stall) begin
        chk("stall_dividend_stable", dvd_dividend, st_dvd);
        chk("stall_divisor_stable", QW'(dvd_divisor), QW'(st_dvs));
      end
      if (div_done || sqrt_done) begin
        if (sb.size() == 0) begin
          tests++; fails++;
          $display("FAIL unexpected_done: got div_done=%0b sqrt_done=%0b expected none (cycle %0d)",
                   div_done, sqrt_done, cyc);
        end else begin
          sb_t e;
          e = sb.pop_front();
          chk("done_owner_sqrt", QW'(sqrt_done), QW'(e.is_sqrt));
          chk("done_owner_div", QW'(div_done), QW'(!e.is_sqrt));
          chk("quotient", e.is_sqrt ? sqrt_quot : div_quot, e.q);
        end
      end
    end
  end

  typedef struct {
    logic          is_sqrt;
    logic [DW-1:0] dvd;
    logic [DW-1:0] dvs;
    int            b;
    logic          drop_early;
    logic [DW:0]   q;
  } vec_t;
  vec_t vec[6];

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got no completion expected $finish");
    $fatal(1);
  end

  initial begin
    int n, c0, lstart, prev, x;
    bit seen;
    logic [DW-1:0] est[4];

    // quotient = floor(2*dividend/divisor): one fractional bit
    vec[0] = '{1'b0, DW'('h64),   DW'('h8),  10, 1'b0, QW'('h19)};
    vec[1] = '{1'b1, DW'('h90),   DW'('hC),   3, 1'b0, QW'('h18)};
    vec[2] = '{1'b1, DW'('h1),    DW'('h3),   1, 1'b0, QW'('h0)};
    vec[3] = '{1'b0, DW'('hFFFF), DW'('h1),   5, 1'b1, QW'('h1FFFE)};
    vec[4] = '{1'b1, DW'('h1000), DW'('h10),  2, 1'b1, QW'('h200)};
    vec[5] = '{1'b0, DW'('h7),    DW'('h2),  20, 1'b0, QW'('h7)};

    rst_n = 1'b0; flush = 1'b0; div_req = 1'b0; sqrt_req = 1'b0;
    div_dvd = '0; div_dvs = '0; sqrt_dvd = '0; sqrt_dvs = '0;
    repeat (3) tick();
    rst_n = 1'b1;
    tick();

    chk("rst_div_grant", QW'(div_grant), '0);
    chk("rst_sqrt_grant", QW'(sqrt_grant), '0);
    chk("rst_done", QW'(div_done | sqrt_done), '0);
    chk("rst_start", QW'(dvd_start), '0);
    chk("rst_error", QW'(error), '0);
    chk("rst_dvd_dividend", dvd_dividend, '0);
    chk("rst_div_quot", div_quot, '0);
    chk("rst_sqrt_quot", sqrt_quot, '0);

    // Both request together after reset: FDIV first, then strict alternation.
    stall_len = 3;
    div_dvd = DW'('h64);  div_dvs = DW'('h8);
    sqrt_dvd = DW'('h90); sqrt_dvs = DW'('hC);
    for (int i = 0; i < 8; i++)
      if (i % 2 == 0) push(1'b0, div_dvd, div_dvs, QW'('h19));
      else            push(1'b1, sqrt_dvd, sqrt_dvs, QW'('h18));
    div_req = 1'b1; sqrt_req = 1'b1;
    n = 0;
    for (int k = 0; k < 300 && n < 8; k++) begin
      tick();
      if (div_done || sqrt_done) n++;
      if (n == 8) begin div_req = 1'b0; sqrt_req = 1'b0; end
    end
    div_req = 1'b0; sqrt_req = 1'b0;
    chk("tie_done_count", QW'(n), QW'(8));
    repeat (3) tick();

    // Single-requester vectors: latency, grant, early request drop.
    foreach (vec[i]) begin
      stall_len = vec[i].b;
      if (vec[i].is_sqrt) begin sqrt_dvd = vec[i].dvd; sqrt_dvs = vec[i].dvs; sqrt_req = 1'b1; end
      else                begin div_dvd  = vec[i].dvd; div_dvs  = vec[i].dvs; div_req  = 1'b1; end
      push(vec[i].is_sqrt, vec[i].dvd, vec[i].dvs, vec[i].q);
      c0 = cyc;
      seen = 1'b0;
      for (int k = 0; k < 4 && !seen; k++) begin tick(); seen = dvd_start; end
      chk("vec_start_latency", QW'(cyc - c0), QW'(1));
      chk("vec_owner_grant", QW'(vec[i].is_sqrt ? sqrt_grant : div_grant), QW'(1));
      chk("vec_other_grant", QW'(vec[i].is_sqrt ? div_grant : sqrt_grant), '0);
      if (vec[i].drop_early) begin div_req = 1'b0; sqrt_req = 1'b0; end
      seen = 1'b0;
      for (int k = 0; k < vec[i].b + 20 && !seen; k++) begin tick(); seen = div_done | sqrt_done; end
      chk("vec_done_latency", QW'(cyc - c0), QW'(3 + vec[i].b));
      div_req = 1'b0; sqrt_req = 1'b0;
      repeat (2) tick();
    end

    // FSQRT back-to-back iterations: minimum start spacing is 4 + busy time.
    stall_len = 3;
    est[0] = DW'('h10); est[1] = DW'('h18); est[2] = DW'('h16); est[3] = DW'('h20);
    push(1'b1, DW'('h200), est[0], QW'('h40));
    push(1'b1, DW'('h200), est[1], QW'('h2A));
    push(1'b1, DW'('h200), est[2], QW'('h2E));
    push(1'b1, DW'('h200), est[3], QW'('h20));
    sqrt_dvd = DW'('h200); sqrt_dvs = est[0]; sqrt_req = 1'b1;
    n = 0; prev = -1;
    for (int k = 0; k < 100 && n < 4; k++) begin
      tick();
      if (dvd_start) begin
        if (prev >= 0) chk("b2b_start_gap", QW'(cyc - prev), QW'(4 + stall_len));
        prev = cyc;
      end
      if (sqrt_done) begin
        n++;
        if (n < 4) sqrt_dvs = est[n];
        else       sqrt_req = 1'b0;
      end
    end
    sqrt_req = 1'b0;
    chk("b2b_done_count", QW'(n), QW'(4));
    repeat (2) tick();

    // Flush in WAIT_DONE: no done, grant drops next cycle, IDLE right after stall falls.
    stall_len = 8;
    div_dvd = DW'('h55); div_dvs = DW'('h5); div_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin tick(); seen = dvd_start; end
    chk("flush_start_seen", QW'(seen), QW'(1));
    repeat (3) tick();
    chk("flush_grant_before", QW'(div_grant), QW'(1));
    flush = 1'b1; div_req = 1'b0;
    tick();
    flush = 1'b0;
    chk("flush_grant_dropped", QW'(div_grant | sqrt_grant), '0);
    seen = 1'b0;
    for (int k = 0; k < 20 && !seen; k++) begin tick(); seen = !dvd_stall; end
    chk("flush_stall_fell", QW'(seen), QW'(1));
    x = cyc;
    sqrt_dvd = DW'('h30); sqrt_dvs = DW'('h4); sqrt_req = 1'b1;
    push(1'b1, sqrt_dvd, sqrt_dvs, QW'('h18));
    seen = 1'b0;
    for (int k = 0; k < 5 && !seen; k++) begin tick(); seen = dvd_start; end
    chk("flush_next_start", QW'(cyc - x), QW'(2));
    seen = 1'b0;
    for (int k = 0; k < 30 && !seen; k++) begin tick(); seen = sqrt_done; end
    chk("flush_next_done", QW'(seen), QW'(1));
    sqrt_req = 1'b0;
    repeat (2) tick();

    // Divider never goes busy: abort with error TIMEOUT cycles after launch.
    never_stall = 1'b1;
    div_dvd = DW'('h9); div_dvs = DW'('h3); div_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin tick(); seen = dvd_start; end
    lstart = cyc;
    seen = 1'b0;
    for (int k = 0; k < TO + 20 && !seen; k++) begin tick(); seen = error; end
    div_req = 1'b0;
    chk("timeout_cycle", QW'(cyc - lstart), QW'(TO));
    tick();
    chk("timeout_grant", QW'(div_grant | sqrt_grant), '0);
    chk("timeout_error_pulse", QW'(error), '0);
    never_stall = 1'b0;
    repeat (2) tick();

    // Async reset in WAIT_DONE, then the first tie goes to FDIV again.
    stall_len = 20;
    div_dvd = DW'('h40); div_dvs = DW'('h2); div_req = 1'b1;
    seen = 1'b0;
    for (int k = 0; k < 4 && !seen; k++) begin tick(); seen = dvd_start; end
    repeat (4) tick();
    #1 rst_n = 1'b0;
    div_req = 1'b0;
    #1;
    chk("arst_grant", QW'(div_grant | sqrt_grant), '0);
    chk("arst_start_done_err", QW'(dvd_start | div_done | sqrt_done | error), '0);
    chk("arst_dvd_dividend", dvd_dividend, '0);
    chk("arst_dvd_divisor", QW'(dvd_divisor), '0);
    chk("arst_div_quot", div_quot, '0);
    chk("arst_sqrt_quot", sqrt_quot, '0);
    sb.delete();
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
    stall_len = 2;
    div_dvd = DW'('h21);  div_dvs = DW'('h3);
    sqrt_dvd = DW'('h50); sqrt_dvs = DW'('h5);
    push(1'b0, div_dvd, div_dvs, QW'('h16));
    push(1'b1, sqrt_dvd, sqrt_dvs, QW'('h20));
    div_req = 1'b1; sqrt_req = 1'b1;
    n = 0;
    for (int k = 0; k < 40 && n < 2; k++) begin
      tick();
      if (div_done)  begin n++; div_req = 1'b0; end
      if (sqrt_done) begin n++; sqrt_req = 1'b0; end
    end
    div_req = 1'b0; sqrt_req = 1'b0;
    chk("arst_tie_done_count", QW'(n), QW'(2));
    repeat (3) tick();
    chk("scoreboard_empty", QW'(sb.size()), '0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
